dram_read_arbiter: RTL
======================

# dram_read_arbiter

- Shares one DRAM read engine (kick/busy/num/addr command port plus return write strobe) between N_REQ stream readers, e.g. the two frame fetchers feeding the display FIFOs.
- Each requester uses the same kick/busy protocol the engine exposes, so requesters connect unchanged.
- The block grants round-robin, issues one burst at a time and steers the returned buffer write strobe to the granted requester's FIFO.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- GUARD, 4, cycles held in DONE before re-arbitration (covers busy synchronizer lag and trailing buf_we)
- TIMEOUT, 1024, max cycles in ISSUE waiting for engine busy

Ports:
- clk  in  1  controller clock
- rst  in  1  reset, synchronous, active-high
- req_kick  in  N_REQ  per-requester kick; held high until its req_busy rises
- req_num  in  N_REQ*32  word count per requester, slice i = [32*i+31:32*i]
- req_addr  in  N_REQ*32  byte address per requester, same slicing
- req_busy  out  N_REQ  per-requester busy, registered
- m_kick  out  1  kick to engine
- m_busy  in  1  engine busy, asynchronous to clk (engine clock domain)
- m_num  out  32  latched word count
- m_addr  out  32  latched address
- buf_we  in  1  engine buffer write strobe (buf_clk domain)
- buf_we_out  out  N_REQ  demuxed write strobes, combinational
- grant_id  out  3  current/last granted index
- err_timeout  out  1  sticky timeout flag
- xfer_cnt  out  32  completed transactions

## Operation
- m_busy passes a 2-flop synchronizer, giving m_busy_s.
- States: IDLE, ISSUE, RUN, DONE.
- IDLE:
  - Any req_kick set: pick the first set bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - Register grant_id, m_num and m_addr from that slice, then go to ISSUE.
- ISSUE:
  - m_kick = 1.
  - m_busy_s = 1: go to RUN and set req_busy[grant_id].
  - Timeout counter reaches TIMEOUT-1: set err_timeout and go to DONE; rr_ptr still advances.
- RUN: m_busy_s = 0 goes to DONE, clears req_busy[grant_id] and increments xfer_cnt (wraps at 2^32).
- DONE:
  - Count GUARD cycles, then rr_ptr = (grant_id+1) mod N_REQ and go to IDLE.
- buf_we_out[i] = buf_we & active & (grant_id == i), where active is registered high from ISSUE entry to DONE exit.
  - grant_id changes only on the IDLE to ISSUE transition, so it is quasi-static in the buf_clk domain.
- Non-granted requesters see req_busy = 0 and keep req_kick asserted; their request stays pending and nothing is lost.
- req_kick dropped while in IDLE: the request is withdrawn, nothing is issued.
- m_num and m_addr stay constant from ISSUE until the next grant.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, grant_id 0, m_kick 0, m_num 0, m_addr 0, req_busy 0, active 0.
  - buf_we_out 0, err_timeout 0, xfer_cnt 0.
- Grant latency: req_kick seen in IDLE at cycle t gives m_kick = 1 at t+1.
- m_busy rising at t reaches m_busy_s at t+2; state is RUN and req_busy high at t+3; m_kick low at t+3.
- m_busy falling at t: req_busy low at t+3, IDLE at t+3+GUARD.
- Minimum request-to-request spacing: 1 + (ISSUE) + (RUN) + GUARD + 1 cycles.
- Simultaneous requests: exactly one grant per IDLE visit; with all N_REQ requests held, grants rotate 0,1,..,N_REQ-1,0.
- rst mid-transaction:
  - Next cycle: IDLE, m_kick 0, active 0 (buf_we_out gated).
  - The engine's in-flight burst is not aborted; its returning data is dropped.
  - Upstream FIFOs must also be reset.
- err_timeout is cleared only by rst.

## Structure
- Package dram_arb_pkg:
  - state enum (IDLE, ISSUE, RUN, DONE)
  - ADDR_W = 32, NUM_W = 32
  - GUARD and TIMEOUT defaults
  - grant_id width function clog2(N_REQ)
- Sub-module rr_pick: combinational round-robin selector; inputs req vector and rr_ptr; outputs valid and index.
- Synchronizer, FSM, counters and demux stay inline.

## Test plan
- Single request: req_kick[2] = 1, addr 0x100_0000, num 64; engine busy for 20 cycles.
  - m_kick high 1 cycle after the kick; m_addr = 0x100_0000 and m_num = 64.
  - req_busy[2] rises at busy+3 and falls at busy fall+3; xfer_cnt = 1.
- All 4 requests held through 8 transactions: grant_id sequence 0,1,2,3,0,1,2,3.
- buf_we routing: 64 buf_we pulses during a grant to requester 1 give 64 pulses on buf_we_out[1] and 0 on the other outputs.
- Timeout: TIMEOUT = 16, engine never asserts busy.
  - err_timeout set 16 cycles after ISSUE entry.
  - IDLE reached after GUARD; next grant goes to the next index.
- rst mid-RUN: every output at its reset value the next cycle; a buf_we pulse after reset produces no buf_we_out.
- Withdrawn kick: req_kick[3] pulses for 1 cycle while a transaction is in RUN; it gets no grant and xfer_cnt is unchanged.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the DRAM read arbiter.
//   arb_state_e : arbiter FSM states
//   ADDR_W/NUM_W: command port widths
//   GUARD_DEF/TIMEOUT_DEF: default guard and issue-timeout lengths
//   clog2()     : index width helper, never returns less than 1
package dram_arb_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned NUM_W       = 32;
   localparam int unsigned GUARD_DEF   = 4;
   localparam int unsigned TIMEOUT_DEF = 1024;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StRun,
      StDone
   } arb_state_e;

   // Smallest w >= 1 with 2**w >= n.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/dram_read_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req_i   : request vector
//   ptr_i   : index searched first; the search wraps modulo N_REQ
//   valid_o : some request is set
//   idx_o   : first set request at or above ptr_i (wrapping)
module rr_pick
   import dram_arb_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IDX_W = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   always_comb begin
      int unsigned cand;
      logic [IDX_W-1:0] ci;
      cand    = 0;
      ci      = '0;
      valid_o = 1'b0;
      idx_o   = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand = 32'(ptr_i) + k;
         if (cand >= N_REQ) begin
            cand = cand - N_REQ;
         end
         ci = cand[IDX_W-1:0];
         if (!valid_o && req_i[ci]) begin
            valid_o = 1'b1;
            idx_o   = ci;
         end
      end
   end

endmodule

// File: rtl/dram_read_arbiter.sv
// Shares one DRAM read engine between N_REQ kick/busy stream readers.
// Grants round-robin, issues one burst at a time and steers the engine's buffer
// write strobe to the granted requester.
//   clk, rst           : clock, synchronous active-high reset
//   req_kick/num/addr  : per-requester command inputs (32-bit slices)
//   req_busy           : per-requester busy, registered
//   m_kick/num/addr    : command to the engine; m_busy is its (async) busy
//   buf_we, buf_we_out : engine write strobe and its per-requester demux
//   grant_id           : current/last granted index
//   err_timeout        : sticky, engine never answered a kick
//   xfer_cnt           : completed transactions
module dram_read_arbiter
   import dram_arb_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned GUARD   = GUARD_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_kick,
   input  logic [N_REQ*NUM_W-1:0]  req_num,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        req_busy,
   output logic                    m_kick,
   input  logic                    m_busy,
   output logic [NUM_W-1:0]        m_num,
   output logic [ADDR_W-1:0]       m_addr,
   input  logic                    buf_we,
   output logic [N_REQ-1:0]        buf_we_out,
   output logic [2:0]              grant_id,
   output logic                    err_timeout,
   output logic [31:0]             xfer_cnt
);

   localparam int unsigned IDX_W = clog2(N_REQ);
   localparam int unsigned CNT_W = clog2((TIMEOUT > GUARD) ? TIMEOUT : GUARD);

   arb_state_e          state_q;
   logic                busy_meta_q, busy_s_q;
   logic [IDX_W-1:0]    rr_ptr_q, grant_q;
   logic                m_kick_q, active_q, err_timeout_q;
   logic [NUM_W-1:0]    m_num_q;
   logic [ADDR_W-1:0]   m_addr_q;
   logic [N_REQ-1:0]    req_busy_q;
   logic [31:0]         xfer_cnt_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                pick_valid;
   logic [IDX_W-1:0]    pick_idx;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i   (req_kick),
      .ptr_i   (rr_ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_meta_q   <= 1'b0;
         busy_s_q      <= 1'b0;
         state_q       <= StIdle;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         m_kick_q      <= 1'b0;
         m_num_q       <= '0;
         m_addr_q      <= '0;
         req_busy_q    <= '0;
         active_q      <= 1'b0;
         err_timeout_q <= 1'b0;
         xfer_cnt_q    <= '0;
         cnt_q         <= '0;
      end else begin
         busy_meta_q <= m_busy;
         busy_s_q    <= busy_meta_q;
         unique case (state_q)
            StIdle: begin
               if (pick_valid) begin
                  grant_q  <= pick_idx;
                  m_num_q  <= req_num[32'(pick_idx)*NUM_W +: NUM_W];
                  m_addr_q <= req_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
                  m_kick_q <= 1'b1;
                  active_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= StIssue;
               end
            end
            StIssue: begin
               if (busy_s_q) begin
                  m_kick_q            <= 1'b0;
                  req_busy_q[grant_q] <= 1'b1;
                  state_q             <= StRun;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  m_kick_q      <= 1'b0;
                  err_timeout_q <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StRun: begin
               if (!busy_s_q) begin
                  req_busy_q[grant_q] <= 1'b0;
                  xfer_cnt_q          <= xfer_cnt_q + 32'd1;
                  cnt_q               <= '0;
                  state_q             <= StDone;
               end
            end
            StDone: begin
               // Guard covers synchronizer lag and trailing buf_we before the next grant.
               if (cnt_q == CNT_W'(GUARD - 1)) begin
                  rr_ptr_q <= (32'(grant_q) == N_REQ - 1) ? '0 : grant_q + 1'b1;
                  active_q <= 1'b0;
                  state_q  <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // grant_q only moves on IDLE->ISSUE, so it is stable whenever active_q is high.
   always_comb begin
      buf_we_out = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         buf_we_out[i] = buf_we & active_q & (grant_q == IDX_W'(i));
      end
   end

   assign req_busy    = req_busy_q;
   assign m_kick      = m_kick_q;
   assign m_num       = m_num_q;
   assign m_addr      = m_addr_q;
   assign grant_id    = 3'(grant_q);
   assign err_timeout = err_timeout_q;
   assign xfer_cnt    = xfer_cnt_q;

endmodule
